// File: rtl/dma_burst_ctrl_pkg.sv
// dma_burst_ctrl_pkg
// Shared definitions for the DMA burst controller: AXI field widths reused by
// the controller parameters, the 4 KB burst boundary, and the FSM encoding.
package dma_burst_ctrl_pkg;

  localparam int AXI_ADDR_W   = 32;
  localparam int AXI_LEN_W    = 8;
  localparam int DMA_BOUNDARY = 4096;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_BEAT  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } dma_state_t;

endpackage

// File: rtl/dma_burst_len.sv
// dma_burst_len
// Combinational burst sizing: blen = min(rem, max_len+1, beats left before the
// next 4 KB boundary).
// Ports:
//   addr     in   ADDR_W   byte address of the next burst (BPB-aligned)
//   rem      in   CNT_W    beats left in the descriptor
//   max_len  in   LEN_W    burst cap, beats-1 encoding
//   blen     out  CNT_W+1  beats in the burst
module dma_burst_len
  import dma_burst_ctrl_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = 32,
  parameter int LEN_W  = AXI_LEN_W,
  parameter int CNT_W  = 16
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [CNT_W-1:0]  rem,
  input  logic [LEN_W-1:0]  max_len,
  output logic [CNT_W:0]    blen
);

  localparam int BW    = $clog2(DMA_BOUNDARY);
  localparam int SHIFT = $clog2(DATA_W/8);
  localparam int W     = CNT_W + 1;

  logic [BW:0]  bytes_left;
  logic [W-1:0] to_bound;
  logic [W-1:0] cap;
  logic [W-1:0] rem_w;
  logic [W-1:0] m1;
  logic         addr_hi_unused;

  // Only the offset inside the 4 KB page matters; an address on the boundary
  // yields the full page (4096 bytes) rather than zero.
  assign bytes_left     = (BW+1)'(DMA_BOUNDARY) - {1'b0, addr[BW-1:0]};
  assign to_bound       = W'(bytes_left >> SHIFT);
  assign cap            = W'(max_len) + W'(1);
  assign rem_w          = W'(rem);
  assign addr_hi_unused = ^addr[ADDR_W-1:BW];

  always_comb begin
    m1   = (rem_w < cap) ? rem_w : cap;
    blen = (m1 < to_bound) ? m1 : to_bound;
  end

endmodule

// File: rtl/dma_burst_ctrl.sv
// dma_burst_ctrl
// Splits one descriptor (base address, word count, direction) into engine
// bursts capped by max_len and never crossing a 4 KB page, and bridges the
// engine's beat interface to a write-source (s_*) or read-sink (m_*) stream.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start, dir, base_addr,          descriptor launch and contents
//   n_words, max_len
//   busy, done, err                 status (done is a pulse, err is sticky)
//   s_valid/s_ready/s_data          write-source stream
//   m_valid/m_ready/m_data          read-sink stream (1-entry output register)
//   dma_valid, dma_address,         engine beat request / burst controls
//   dma_wdata, dma_wstrb, dma_len
//   dma_rdata, dma_beat_ready,      engine beat response / status
//   dma_idle, dma_error
//
// state | meaning
// IDLE  | waiting for start
// CALC  | size the next burst, load dma_len
// WAIT  | wait for the engine to go idle before issuing the burst
// BEAT  | move beats; address and length held stable
// DRAIN | wait for engine idle (and read register empty on the last burst)
// DONE  | done pulse, back to IDLE
module dma_burst_ctrl
  import dma_burst_ctrl_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = 32,
  parameter int LEN_W  = AXI_LEN_W,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                dir,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    n_words,
  input  logic [LEN_W-1:0]    max_len,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATA_W-1:0]   m_data,
  output logic                dma_valid,
  output logic [ADDR_W-1:0]   dma_address,
  output logic [DATA_W-1:0]   dma_wdata,
  output logic [DATA_W/8-1:0] dma_wstrb,
  input  logic [DATA_W-1:0]   dma_rdata,
  input  logic                dma_beat_ready,
  output logic [LEN_W-1:0]    dma_len,
  input  logic                dma_idle,
  input  logic                dma_error
);

  localparam int SHIFT = $clog2(DATA_W/8);
  localparam int W     = CNT_W + 1;

  dma_state_t        state;
  logic              dir_q;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  rem;
  logic [LEN_W-1:0]  max_len_q;
  logic [W-1:0]      blen;
  logic [W-1:0]      bcnt;
  logic [W-1:0]      blen_c;
  logic              fire;
  logic              last_beat;
  logic              rd_slot;

  dma_burst_len #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .CNT_W  (CNT_W)
  ) u_burst_len (
    .addr    (addr),
    .rem     (rem),
    .max_len (max_len_q),
    .blen    (blen_c)
  );

  assign dma_address = addr;
  // Read beats are only requested when the output register can take them.
  assign rd_slot     = !m_valid || m_ready;

  always_comb begin
    dma_valid = 1'b0;
    s_ready   = 1'b0;
    dma_wdata = '0;
    dma_wstrb = '0;
    if (state == ST_BEAT) begin
      if (dir_q) begin
        dma_valid = s_valid;
        s_ready   = dma_beat_ready;
        dma_wdata = s_data;
        dma_wstrb = '1;
      end else begin
        dma_valid = rd_slot;
      end
    end
  end

  assign fire      = dma_valid && dma_beat_ready;
  assign last_beat = fire && (bcnt == blen - W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      dir_q     <= 1'b0;
      addr      <= '0;
      rem       <= '0;
      max_len_q <= '0;
      blen      <= '0;
      bcnt      <= '0;
      dma_len   <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
    end else begin
      done <= 1'b0;
      if (dma_error && state != ST_IDLE) err <= 1'b1;

      if (fire && !dir_q) begin
        m_data  <= dma_rdata;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (n_words != '0) begin
              dir_q     <= dir;
              addr      <= base_addr;
              rem       <= n_words;
              max_len_q <= max_len;
              err       <= 1'b0;
              busy      <= 1'b1;
              state     <= ST_CALC;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_CALC: begin
          blen    <= blen_c;
          dma_len <= LEN_W'(blen_c - W'(1));
          bcnt    <= '0;
          // Burst not yet issued: an error here drops it outright.
          if (dma_error) begin
            rem   <= '0;
            state <= ST_DRAIN;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dma_error) begin
            rem   <= '0;
            state <= ST_DRAIN;
          end else if (dma_idle) begin
            state <= ST_BEAT;
          end
        end
        ST_BEAT: begin
          if (fire) begin
            if (last_beat) begin
              addr  <= addr + (ADDR_W'(blen) << SHIFT);
              // After an error the burst is finished but nothing else is issued.
              rem   <= (err || dma_error) ? '0 : rem - CNT_W'(blen);
              state <= ST_DRAIN;
            end else begin
              bcnt <= bcnt + W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (dma_error) begin
            rem <= '0;
          end else if (dma_idle) begin
            if (rem == '0) begin
              if (dir_q || !m_valid) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_DONE;
              end
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_burst_ctrl.sv
module tb_dma_burst_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        dir;
  logic [31:0] base_addr;
  logic [15:0] n_words;
  logic [7:0]  max_len;
  logic        busy, done, err;
  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic        m_valid, m_ready;
  logic [31:0] m_data;
  logic        dma_valid;
  logic [31:0] dma_address;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_wstrb;
  logic [31:0] dma_rdata;
  logic        dma_beat_ready;
  logic [7:0]  dma_len;
  logic        dma_idle;
  logic        dma_error;

  // bench controls
  logic tb_clr, s_en, s_gap, m_tog, cur_dir;
  int   idle_hold;
  int   checks = 0;
  int   errors = 0;

  // monitor state
  int          cyc_cnt, n_beats, n_bursts, w_idx, rd_idx, n_pop;
  int          wdata_err, wstrb_err, stab_err, m_err, done_cnt, busy_cyc;
  int          valid_cyc, valid_idle_err, beat_in, idle_cnt;
  logic        in_burst;
  logic [31:0] cur_addr;
  logic [7:0]  cur_len;
  logic [31:0] burst_addr [0:7];
  logic [7:0]  burst_len  [0:7];
  logic        fire_tb, last_tb;

  dma_burst_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .dir            (dir),
    .base_addr      (base_addr),
    .n_words        (n_words),
    .max_len        (max_len),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .dma_valid      (dma_valid),
    .dma_address    (dma_address),
    .dma_wdata      (dma_wdata),
    .dma_wstrb      (dma_wstrb),
    .dma_rdata      (dma_rdata),
    .dma_beat_ready (dma_beat_ready),
    .dma_len        (dma_len),
    .dma_idle       (dma_idle),
    .dma_error      (dma_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source/engine stand-ins: numbered data words, 50% patterns from cyc_cnt.
  assign s_data    = 32'h5000_0000 + w_idx;
  assign dma_rdata = 32'hA500_0000 + rd_idx;
  assign s_valid   = s_en & (s_gap ? cyc_cnt[1] : 1'b1);
  assign m_ready   = m_tog ? cyc_cnt[0] : 1'b1;
  assign dma_idle  = (idle_cnt == 0);
  assign fire_tb   = dma_valid && dma_beat_ready;
  assign last_tb   = fire_tb && (in_burst ? (beat_in == int'(cur_len)) : (dma_len == 8'd0));

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (tb_clr) begin
      n_beats <= 0; n_bursts <= 0; w_idx <= 0; rd_idx <= 0; n_pop <= 0;
      wdata_err <= 0; wstrb_err <= 0; stab_err <= 0; m_err <= 0;
      done_cnt <= 0; busy_cyc <= 0; valid_cyc <= 0; valid_idle_err <= 0;
      beat_in <= 0; in_burst <= 1'b0; idle_cnt <= 0;
      cur_addr <= '0; cur_len <= '0;
    end else if (rst_n) begin
      if (done) done_cnt <= done_cnt + 1;
      if (busy) busy_cyc <= busy_cyc + 1;
      if (dma_valid) valid_cyc <= valid_cyc + 1;
      if (dma_valid && !dma_idle) valid_idle_err <= valid_idle_err + 1;
      if (start) idle_cnt <= idle_hold;
      else if (last_tb) idle_cnt <= idle_hold;
      else if (idle_cnt != 0) idle_cnt <= idle_cnt - 1;
      if (fire_tb) begin
        n_beats <= n_beats + 1;
        if (dma_wstrb !== (cur_dir ? 4'hF : 4'h0)) wstrb_err <= wstrb_err + 1;
        if (cur_dir) begin
          if (dma_wdata !== 32'h5000_0000 + w_idx) wdata_err <= wdata_err + 1;
          w_idx <= w_idx + 1;
        end else begin
          rd_idx <= rd_idx + 1;
        end
        if (!in_burst) begin
          if (n_bursts < 8) begin
            burst_addr[n_bursts[2:0]] <= dma_address;
            burst_len[n_bursts[2:0]]  <= dma_len;
          end
          n_bursts <= n_bursts + 1;
          cur_addr <= dma_address;
          cur_len  <= dma_len;
          in_burst <= (dma_len != 8'd0);
          beat_in  <= 1;
        end else begin
          if (dma_address !== cur_addr || dma_len !== cur_len) stab_err <= stab_err + 1;
          if (beat_in == int'(cur_len)) in_burst <= 1'b0;
          beat_in <= beat_in + 1;
        end
      end
      if (m_valid && m_ready) begin
        if (m_data !== 32'hA500_0000 + n_pop) m_err <= m_err + 1;
        n_pop <= n_pop + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    tb_clr = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0;
  endtask

  task automatic launch(input logic d, input logic [31:0] b, input logic [15:0] n,
                        input logic [7:0] ml);
    dir = d; base_addr = b; n_words = n; max_len = ml; cur_dir = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_beats(input int n, input int max_cyc, input string tag);
    int k;
    k = 0;
    while (n_beats < n && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, (n_beats >= n)}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dir = 1'b0; base_addr = '0; n_words = '0;
    max_len = '0; dma_beat_ready = 1'b1; dma_error = 1'b0;
    tb_clr = 1'b1; s_en = 1'b0; s_gap = 1'b0; m_tog = 1'b0; cur_dir = 1'b0;
    idle_hold = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dma_valid", {31'd0, dma_valid}, 32'd0);
    chk("rst_dma_len", {24'd0, dma_len}, 32'd0);
    chk("rst_dma_address", dma_address, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    rst_n = 1'b1;
    tb_clr = 1'b0;
    @(negedge clk);

    // write, 20 beats, cap 8 -> 8,8,4
    clr();
    s_en = 1'b1;
    launch(1'b1, 32'h0, 16'd20, 8'd7);
    wait_done(300, "wr_done");
    @(negedge clk);
    chk("wr_bursts", n_bursts, 3);
    chk("wr_addr0", burst_addr[0], 32'h00);
    chk("wr_len0", {24'd0, burst_len[0]}, 32'd7);
    chk("wr_addr1", burst_addr[1], 32'h20);
    chk("wr_len1", {24'd0, burst_len[1]}, 32'd7);
    chk("wr_addr2", burst_addr[2], 32'h40);
    chk("wr_len2", {24'd0, burst_len[2]}, 32'd3);
    chk("wr_beats", n_beats, 20);
    chk("wr_wdata", wdata_err, 0);
    chk("wr_wstrb", wstrb_err, 0);
    chk("wr_stable", stab_err, 0);
    chk("wr_done_cnt", done_cnt, 1);
    chk("wr_err", {31'd0, err}, 32'd0);
    chk("wr_busy", {31'd0, busy}, 32'd0);

    // read across a 4 KB boundary, sink ready 50%
    clr();
    s_en = 1'b0; m_tog = 1'b1;
    launch(1'b0, 32'h0000_0FF0, 16'd16, 8'd255);
    wait_done(400, "rd_done");
    @(negedge clk);
    chk("rd_bursts", n_bursts, 2);
    chk("rd_addr0", burst_addr[0], 32'h0FF0);
    chk("rd_len0", {24'd0, burst_len[0]}, 32'd3);
    chk("rd_addr1", burst_addr[1], 32'h1000);
    chk("rd_len1", {24'd0, burst_len[1]}, 32'd11);
    chk("rd_beats", n_beats, 16);
    chk("rd_pops", n_pop, 16);
    chk("rd_order", m_err, 0);
    chk("rd_wstrb", wstrb_err, 0);
    chk("rd_m_valid", {31'd0, m_valid}, 32'd0);
    m_tog = 1'b0;

    // zero-length descriptor; start held into the done cycle is ignored
    clr();
    n_words = 16'd0; cur_dir = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("zero_done_drop", {31'd0, done}, 32'd0);
    repeat (4) @(negedge clk);
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_valid", valid_cyc, 0);
    chk("zero_busy_cyc", busy_cyc, 0);

    // error during burst 1 of 3
    clr();
    s_en = 1'b1;
    launch(1'b1, 32'h2000, 16'd24, 8'd7);
    wait_beats(3, 50, "err_reach");
    dma_error = 1'b1;
    @(negedge clk);
    dma_error = 1'b0;
    wait_done(200, "err_done");
    @(negedge clk);
    chk("err_bursts", n_bursts, 1);
    chk("err_beats", n_beats, 8);
    chk("err_flag", {31'd0, err}, 32'd1);
    chk("err_done_cnt", done_cnt, 1);
    repeat (5) @(negedge clk);
    chk("err_sticky", {31'd0, err}, 32'd1);
    chk("err_no_more", n_bursts, 1);
    clr();
    launch(1'b1, 32'h3000, 16'd4, 8'd3);
    chk("err_cleared", {31'd0, err}, 32'd0);
    wait_done(100, "err_next_done");
    chk("err_next_beats", n_beats, 4);

    // start while busy ignored, then reset mid-burst
    @(negedge clk);
    clr();
    launch(1'b1, 32'h100, 16'd20, 8'd7);
    @(negedge clk);
    launch(1'b1, 32'h800, 16'd4, 8'd3);
    wait_beats(5, 50, "busy_reach");
    chk("busy_addr0", burst_addr[0], 32'h100);
    chk("busy_len0", {24'd0, burst_len[0]}, 32'd7);
    chk("busy_bursts", n_bursts, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, dma_valid}, 32'd0);
    chk("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("mid_rst_wstrb", {28'd0, dma_wstrb}, 32'd0);
    chk("mid_rst_len", {24'd0, dma_len}, 32'd0);
    chk("mid_rst_addr", dma_address, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr();
    launch(1'b1, 32'h40, 16'd4, 8'd3);
    wait_done(100, "post_rst_done");
    @(negedge clk);
    chk("post_rst_bursts", n_bursts, 1);
    chk("post_rst_addr", burst_addr[0], 32'h40);
    chk("post_rst_len", {24'd0, burst_len[0]}, 32'd3);
    chk("post_rst_beats", n_beats, 4);
    chk("post_rst_wdata", wdata_err, 0);

    // engine busy 10 cycles before each burst, source stalls
    clr();
    idle_hold = 10; s_gap = 1'b1;
    launch(1'b1, 32'h0, 16'd20, 8'd7);
    wait_done(800, "idle_done");
    @(negedge clk);
    chk("idle_bursts", n_bursts, 3);
    chk("idle_len2", {24'd0, burst_len[2]}, 32'd3);
    chk("idle_addr2", burst_addr[2], 32'h40);
    chk("idle_beats", n_beats, 20);
    chk("idle_wdata", wdata_err, 0);
    chk("idle_valid_wait", valid_idle_err, 0);
    chk("idle_stable", stab_err, 0);
    chk("idle_done_cnt", done_cnt, 1);
    idle_hold = 0; s_gap = 1'b0; s_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
